// File: rtl/beverage_ctrl.sv
// Vending and brew controller: coin credit, price check, change and timed
// ingredient dispensing, with every output driven straight from a register.
`timescale 1ns/1ps
module beverage_ctrl #(
    parameter int NUM_DRINKS = 4,
    parameter int CREDIT_W   = 8,
    parameter int NUM_ING    = 5,
    parameter logic [NUM_DRINKS*CREDIT_W-1:0] PRICE_TABLE  = {8'd10, 8'd7, 8'd5, 8'd3},
    parameter logic [NUM_DRINKS*NUM_ING-1:0]  RECIPE_TABLE = {5'b01111, 5'b00111, 5'b00011, 5'b00001},
    parameter int TICK_DIV   = 100000000,
    parameter int STEP_SECS  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  coin_one,
    input  logic                  coin_five,
    input  logic                  cancel,
    input  logic                  brew,
    input  logic [NUM_DRINKS-1:0] drink_sel,
    output logic [CREDIT_W-1:0]   credit,
    output logic [CREDIT_W-1:0]   change,
    output logic [NUM_ING-1:0]    ingredients,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = (STEP_SECS > 1) ? $clog2(STEP_SECS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(STEP_SECS - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPENSE = 2'd1,
        S_DONE     = 2'd2
    } state_t;

    state_t              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] change_q;
    logic [NUM_ING-1:0]  ingr_q;
    logic [NUM_ING-1:0]  mask_q;
    logic                busy_q;
    logic                done_q;
    logic [1:0]          err_q;
    logic [PW-1:0]       presc_q;
    logic [TW-1:0]       tick_q;

    logic [2:0]          coin_val_d;
    logic                coin_any_d;
    logic [CREDIT_W-1:0] credit_inc_d;
    logic [CREDIT_W-1:0] coin_only_d;
    logic [CREDIT_W-1:0] price_d;
    logic [NUM_ING-1:0]  recipe_d;
    logic                sel_ok_d;
    logic [NUM_ING-1:0]  mask_clr_d;

    function automatic logic [NUM_ING-1:0] low_bit(input logic [NUM_ING-1:0] m);
        return m & (~m + NUM_ING'(1));
    endfunction

    function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                    input logic [2:0] b);
        logic [CREDIT_W:0] s;
        s = {1'b0, a} + (CREDIT_W+1)'(b);
        return s[CREDIT_W] ? {CREDIT_W{1'b1}} : s[CREDIT_W-1:0];
    endfunction

    // Coin value, saturated credit, and price/recipe of the selected drink
    always_comb begin
        coin_val_d   = (coin_one ? 3'd1 : 3'd0) + (coin_five ? 3'd5 : 3'd0);
        coin_any_d   = coin_one | coin_five;
        credit_inc_d = sat_add(credit_q, coin_val_d);
        coin_only_d  = sat_add({CREDIT_W{1'b0}}, coin_val_d);
        sel_ok_d     = $onehot(drink_sel);
        mask_clr_d   = mask_q & ~low_bit(mask_q);
        price_d      = {CREDIT_W{1'b0}};
        recipe_d     = {NUM_ING{1'b0}};
        for (int i = 0; i < NUM_DRINKS; i++) begin
            price_d  = price_d  | (drink_sel[i] ? PRICE_TABLE[i*CREDIT_W +: CREDIT_W] : {CREDIT_W{1'b0}});
            recipe_d = recipe_d | (drink_sel[i] ? RECIPE_TABLE[i*NUM_ING +: NUM_ING] : {NUM_ING{1'b0}});
        end
    end

    // Controller FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            credit_q <= {CREDIT_W{1'b0}};
            change_q <= {CREDIT_W{1'b0}};
            ingr_q   <= {NUM_ING{1'b0}};
            mask_q   <= {NUM_ING{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 2'b00;
            presc_q  <= {PW{1'b0}};
            tick_q   <= {TW{1'b0}};
        end else begin
            err_q    <= 2'b00;
            done_q   <= 1'b0;
            credit_q <= credit_inc_d;
            case (state_q)
                S_IDLE: begin
                    if (coin_any_d) begin
                        change_q <= {CREDIT_W{1'b0}};
                    end
                    if (cancel) begin
                        // A same-cycle coin is part of the refund; a zero refund keeps old change
                        credit_q <= {CREDIT_W{1'b0}};
                        if (credit_inc_d != {CREDIT_W{1'b0}}) begin
                            change_q <= credit_inc_d;
                        end
                    end else if (brew) begin
                        if (!sel_ok_d) begin
                            err_q <= 2'b01;
                        end else if (credit_q < price_d) begin
                            err_q <= 2'b10;
                        end else begin
                            change_q <= credit_q - price_d;
                            credit_q <= coin_only_d;
                            mask_q   <= recipe_d;
                            ingr_q   <= low_bit(recipe_d);
                            busy_q   <= 1'b1;
                            presc_q  <= {PW{1'b0}};
                            tick_q   <= {TW{1'b0}};
                            state_q  <= S_DISPENSE;
                        end
                    end
                end
                S_DISPENSE: begin
                    if (mask_q == {NUM_ING{1'b0}}) begin
                        ingr_q  <= {NUM_ING{1'b0}};
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_q <= {PW{1'b0}};
                        if (tick_q == TICK_LAST) begin
                            tick_q <= {TW{1'b0}};
                            mask_q <= mask_clr_d;
                            if (mask_clr_d == {NUM_ING{1'b0}}) begin
                                ingr_q  <= {NUM_ING{1'b0}};
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                ingr_q <= low_bit(mask_clr_d);
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign credit      = credit_q;
    assign change      = change_q;
    assign ingredients = ingr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
endmodule
